// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator that copies LEN 32-bit words from a source
// word range to a destination word range, one outstanding transaction at a
// time, over the native valid/ready/wstrb memory bus.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  command strobe, accepted while idle or in done cycle
//   src_addr, dst_addr     byte addresses, bits [1:0] ignored
//   len                    word count (0 is legal: immediate done, no traffic)
//   busy, done             status; done is a one-cycle pulse
//   mem_valid/mem_ready    request handshake
//   mem_wstrb              0000 read, 1111 full-word write
//   mem_addr/mem_wdata     request address / write data
//   mem_rdata              read data, valid with mem_ready
//
// Optional feature (macro MEM_COPY_DMA_FILL_EN): adds fill / fill_data inputs;
// a fill command writes fill_data to LEN consecutive destination words and
// performs no reads.
module mem_copy_dma #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
`ifdef MEM_COPY_DMA_FILL_EN
   input  logic             fill,
   input  logic [31:0]      fill_data,
`endif
   output logic             busy,
   output logic             done,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [3:0]       mem_wstrb,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] RGAP = 3'd2;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] WGAP = 3'd4;

   logic [2:0]       state;
   logic [29:0]      src_w;     // word pointers; +1 wraps the byte address mod 2^32
   logic [29:0]      dst_w;
   logic [LEN_W-1:0] rem;
   logic [31:0]      buf_q;
   logic             zdone;     // done pulse for a zero-length command
`ifdef MEM_COPY_DMA_FILL_EN
   logic             fill_q;
`endif

   logic       last;
   logic       accept;
   logic [2:0] first_st;
   logic [2:0] loop_st;
   logic       unused_addr_lsbs;

   assign unused_addr_lsbs = &{1'b0, src_addr[1:0], dst_addr[1:0]};

   // The WGAP cycle of the final word is the done cycle; it counts as idle.
   assign last   = (state == WGAP) && (rem == '0);
   assign accept = start && ((state == IDLE) || last);

`ifdef MEM_COPY_DMA_FILL_EN
   assign first_st = fill ? WR : RD;
   assign loop_st  = fill_q ? WR : RD;
`else
   assign first_st = RD;
   assign loop_st  = RD;
`endif

   // Bus outputs decode straight from registered state so reset drops
   // mem_valid immediately and the request fields hold while it waits.
   assign mem_valid = (state == RD) || (state == WR);
   assign mem_wstrb = (state == WR) ? 4'hF : 4'h0;
   assign mem_addr  = {((state == WR) ? dst_w : src_w), 2'b00};
   assign mem_wdata = buf_q;
   assign done      = zdone || last;
   assign busy      = (state != IDLE) && !last;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         src_w  <= '0;
         dst_w  <= '0;
         rem    <= '0;
         buf_q  <= '0;
         zdone  <= 1'b0;
`ifdef MEM_COPY_DMA_FILL_EN
         fill_q <= 1'b0;
`endif
      end else begin
         zdone <= 1'b0;
         if (accept) begin
            if (len != '0) begin
               src_w <= src_addr[31:2];
               dst_w <= dst_addr[31:2];
               rem   <= len;
               state <= first_st;
`ifdef MEM_COPY_DMA_FILL_EN
               fill_q <= fill;
               if (fill) buf_q <= fill_data;
`endif
            end else begin
               zdone <= 1'b1;
               state <= IDLE;
            end
         end else begin
            case (state)
               RD: if (mem_ready) begin
                  buf_q <= mem_rdata;
                  state <= RGAP;
               end
               RGAP: state <= WR;
               WR: if (mem_ready) begin
                  rem   <= rem - LEN_W'(1);
                  src_w <= src_w + 30'd1;
                  dst_w <= dst_w + 30'd1;
                  state <= WGAP;
               end
               WGAP: state <= (rem != '0) ? loop_st : IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: RAM responder with random ready
// delay, a reference copy model that queues expected bus transactions, and a
// monitor that pops and compares each completed transaction.
module tb_mem_copy_dma;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
`ifdef MEM_COPY_DMA_FILL_EN
   logic        fill = 1'b0;
   logic [31:0] fill_data = '0;
`endif
   logic        busy, done, mem_valid;
   logic        mem_ready = 1'b0;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   mem_copy_dma #(.LEN_W(16)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEM_COPY_DMA_FILL_EN
      .fill(fill), .fill_data(fill_data),
`endif
      .busy(busy), .done(done), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;
   int n_rd = 0, n_wr = 0, n_done = 0;
   bit sb_en = 1'b1;
   int dmin = 0, dmax = 0;

   typedef struct {
      logic [3:0]  st;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;
   txn_t expq[$];

   logic [31:0] ram  [logic [29:0]];
   logic [31:0] refm [logic [29:0]];

   function automatic logic [31:0] init_word(logic [29:0] w);
      return {w, 2'b01} ^ 32'h3C5A_96E1;
   endfunction
   function automatic logic [31:0] ram_rd(logic [29:0] w);
      return ram.exists(w) ? ram[w] : init_word(w);
   endfunction
   function automatic logic [31:0] ref_rd(logic [29:0] w);
      return refm.exists(w) ? refm[w] : init_word(w);
   endfunction

   task automatic check(string nm, logic [67:0] act, logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Responder: ready pulses for one cycle after a per-request random delay.
   int cnt = 0, cur_dly = 0;
   always @(posedge clk or negedge resetn) begin
      int d;
      if (!resetn) begin
         mem_ready <= 1'b0;
         cnt       <= 0;
      end else if (mem_ready) begin
         mem_ready <= 1'b0;
      end else if (mem_valid) begin
         d = (cnt == 0) ? int'($urandom_range(dmax, dmin)) : cur_dly;
         cur_dly <= d;
         if (cnt >= d) begin
            mem_ready <= 1'b1;
            mem_rdata <= ram_rd(mem_addr[31:2]);
            cnt       <= 0;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   // Monitor: protocol checks plus scoreboard pop on each completion.
   initial begin
      logic        pv, pr;
      logic [3:0]  ps;
      logic [31:0] pa, pd;
      txn_t        e;
      pv = 1'b0; pr = 1'b0; ps = '0; pa = '0; pd = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            pv = 1'b0;
            pr = 1'b0;
         end else begin
            if (pv && !pr && mem_valid)
               check("stable", {mem_wstrb, mem_addr, mem_wdata}, {ps, pa, pd});
            if (pv && pr)
               check("gap", 68'(mem_valid), 68'd0);
            if (mem_valid && mem_ready) begin
               if (mem_wstrb == 4'hF) begin
                  n_wr++;
                  ram[mem_addr[31:2]] = mem_wdata;
               end else begin
                  n_rd++;
               end
               if (sb_en) begin
                  if (expq.size() == 0) begin
                     check("unexpected_txn", {mem_wstrb, mem_addr, mem_wdata}, 68'd0);
                  end else begin
                     e = expq.pop_front();
                     check("txn", {mem_wstrb, mem_addr, (mem_wstrb == 4'hF) ? mem_wdata : 32'd0},
                           {e.st, e.a, e.d});
                  end
               end
            end
            if (done) begin
               n_done++;
               check("busy_at_done", 68'(busy), 68'd0);
            end
            pv = mem_valid; pr = mem_ready; ps = mem_wstrb; pa = mem_addr; pd = mem_wdata;
         end
      end
   end

   // Reference model: ascending word-by-word copy (or fill) on the model RAM.
   task automatic push_copy(logic [31:0] src, logic [31:0] dst, int ln, bit fl, logic [31:0] fd);
      logic [31:0] sa, da, v;
      sa = src & 32'hFFFF_FFFC;
      da = dst & 32'hFFFF_FFFC;
      for (int i = 0; i < ln; i++) begin
         if (!fl) begin
            v = ref_rd(sa[31:2]);
            expq.push_back('{4'h0, sa, 32'd0});
         end else begin
            v = fd;
         end
         expq.push_back('{4'hF, da, v});
         refm[da[31:2]] = v;
         sa = sa + 32'd4;
         da = da + 32'd4;
      end
   endtask

   // Called at a negedge; drives start for one cycle. c0 = cycle of start.
   task automatic issue(logic [31:0] src, logic [31:0] dst, int ln, bit fl,
                        logic [31:0] fd, bit push, output int c0);
      start = 1'b1; src_addr = src; dst_addr = dst; len = 16'(ln);
`ifdef MEM_COPY_DMA_FILL_EN
      fill = fl; fill_data = fd;
`endif
      c0 = cyc;
      if (push) push_copy(src, dst, ln, fl, fd);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(int maxc, output int dc, output bit busy_all);
      bit ok;
      ok = 1'b0; dc = 0; busy_all = 1'b1;
      for (int k = 0; k < maxc; k++) begin
         if (done) begin
            ok = 1'b1;
            dc = cyc;
            break;
         end
         if (!busy) busy_all = 1'b0;
         @(negedge clk);
      end
      if (!ok) check("done_timeout", 68'd0, 68'd1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, dc, r0, w0, d0;
      bit ba;
      logic [31:0] s, d;
      int ln;

      repeat (3) @(negedge clk);
      check("rst_busy", 68'(busy), 68'd0);
      check("rst_done", 68'(done), 68'd0);
      check("rst_bus", {mem_valid, mem_wstrb, mem_addr, mem_wdata}, 68'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Basic copy
      ram[30'h10] = 32'hA1; ram[30'h11] = 32'hB2; ram[30'h12] = 32'hC3;
      refm[30'h10] = 32'hA1; refm[30'h11] = 32'hB2; refm[30'h12] = 32'hC3;
      r0 = n_rd; w0 = n_wr; d0 = n_done;
      issue(32'h40, 32'h100, 3, 1'b0, 32'd0, 1'b1, c0);
      wait_done(200, dc, ba);
      check("basic_done_cycle", 68'(dc - c0), 68'd18);
      check("basic_busy", 68'(ba), 68'd1);
      @(negedge clk);
      check("basic_reads", 68'(n_rd - r0), 68'd3);
      check("basic_writes", 68'(n_wr - w0), 68'd3);
      check("basic_done_once", 68'(n_done - d0), 68'd1);
      check("basic_ram0", 68'(ram_rd(30'h40)), 68'hA1);
      check("basic_ram1", 68'(ram_rd(30'h41)), 68'hB2);
      check("basic_ram2", 68'(ram_rd(30'h42)), 68'hC3);

      // Zero length
      d0 = n_done;
      issue(32'h40, 32'h800, 0, 1'b0, 32'd0, 1'b1, c0);
      check("zero_done", 68'(done), 68'd1);
      check("zero_busy", 68'(busy), 68'd0);
      check("zero_valid", 68'(mem_valid), 68'd0);
      @(negedge clk);
      check("zero_valid2", {busy, mem_valid, done}, 68'd0);
      check("zero_done_once", 68'(n_done - d0), 68'd1);

      // Slow responder
      dmin = 5; dmax = 5;
      issue(32'h0000_0203, 32'h0000_0601, 3, 1'b0, 32'd0, 1'b1, c0);
      wait_done(400, dc, ba);
      @(negedge clk);

      // Ignored start mid-copy, then back-to-back start in the done cycle
      dmin = 0; dmax = 2;
      issue(32'h200, 32'h300, 4, 1'b0, 32'd0, 1'b1, c0);
      repeat (7) @(negedge clk);
      issue(32'h900, 32'hA00, 5, 1'b0, 32'd0, 1'b0, c0);
      wait_done(400, dc, ba);
      issue(32'h300, 32'h380, 3, 1'b0, 32'd0, 1'b1, c0);
      wait_done(400, dc, ba);
      @(negedge clk);

      // Destination wrap
      dmin = 0; dmax = 0;
      issue(32'h500, 32'hFFFF_FFFC, 2, 1'b0, 32'd0, 1'b1, c0);
      wait_done(200, dc, ba);
      @(negedge clk);

`ifdef MEM_COPY_DMA_FILL_EN
      r0 = n_rd; w0 = n_wr;
      issue(32'h0, 32'h700, 4, 1'b1, 32'hDEAD_BEEF, 1'b1, c0);
      wait_done(200, dc, ba);
      check("fill_done_cycle", 68'(dc - c0), 68'd12);
      @(negedge clk);
      check("fill_reads", 68'(n_rd - r0), 68'd0);
      check("fill_writes", 68'(n_wr - w0), 68'd4);
`endif

      // Randomized copies, overlapping ranges allowed
      for (int t = 0; t < 10; t++) begin
         dmin = 0; dmax = int'($urandom_range(3, 0));
         ln = int'($urandom_range(6, 1));
         s = 32'h1000 + ($urandom_range(31, 0) << 2) + $urandom_range(3, 0);
         d = 32'h1000 + ($urandom_range(31, 0) << 2) + $urandom_range(3, 0);
`ifdef MEM_COPY_DMA_FILL_EN
         issue(s, d, ln, $urandom_range(1, 0) == 1, $urandom, 1'b1, c0);
`else
         issue(s, d, ln, 1'b0, 32'd0, 1'b1, c0);
`endif
         wait_done(600, dc, ba);
      end
      @(negedge clk);
      check("queue_drained", 68'(expq.size()), 68'd0);

      // Reset during a write: no done, then a normal copy afterwards
      sb_en = 1'b0;
      dmin = 5; dmax = 5;
      issue(32'h40, 32'h2000, 2, 1'b0, 32'd0, 1'b0, c0);
      for (int k = 0; k < 50 && !(mem_valid && mem_wstrb == 4'hF); k++) @(negedge clk);
      check("rst_reached_wr", {mem_valid, mem_wstrb}, 68'h1F);
      d0 = n_done;
      #2 resetn = 1'b0;
      #1;
      check("rst_valid_drop", 68'(mem_valid), 68'd0);
      check("rst_busy_drop", 68'(busy), 68'd0);
      repeat (3) @(negedge clk);
      check("rst_no_done", 68'(n_done - d0), 68'd0);
      resetn = 1'b1;
      sb_en = 1'b1;
      dmin = 0; dmax = 0;
      @(negedge clk);
      issue(32'h2000, 32'h2100, 2, 1'b0, 32'd0, 1'b1, c0);
      wait_done(200, dc, ba);
      check("post_rst_done_cycle", 68'(dc - c0), 68'd12);
      @(negedge clk);
      check("final_queue_drained", 68'(expq.size()), 68'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
